// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, instruction width, NOP word and default reset PC.
package cpu_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = '0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register between fetch and decode with load / bubble / hold controls.
// Bubble wins over load; with neither asserted the register holds its contents.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_load,
  input  logic                   i_bubble,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  input  logic [ADDR_WIDTH-1:0]  i_pc_plus4,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
  output logic                   o_valid
);

  logic [INSTR_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0]  pc_q;
  logic [ADDR_WIDTH-1:0]  pc_plus4_q;
  logic                   valid_q;

  // A bubble only clears the instruction and valid flag; PC fields keep their last value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (i_bubble) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (i_load) begin
      instr_q    <= i_instr;
      pc_q       <= i_pc;
      pc_plus4_q <= i_pc_plus4;
      valid_q    <= 1'b1;
    end
  end

  assign o_instr    = instr_q;
  assign o_pc       = pc_q;
  assign o_pc_plus4 = pc_plus4_q;
  assign o_valid    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the req/ack instruction memory port,
// absorbs stalls with a one-entry skid buffer and drains outstanding requests on redirect.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic [ADDR_WIDTH-1:0]  i_target_pc,
  output logic                   o_imem_req,
  output logic [ADDR_WIDTH-1:0]  o_imem_addr,
  input  logic                   i_imem_ack,
  input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
  output logic                   o_bubble
);

  fetch_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_WIDTH-1:0]  skid_pc_q, skid_pc_d;
  logic [ADDR_WIDTH-1:0]  drain_target_q, drain_target_d;

  logic [ADDR_WIDTH-1:0]  target_aligned;
  logic [ADDR_WIDTH-1:0]  fetch_pc_plus4;
  logic [ADDR_WIDTH-1:0]  skid_pc_plus4;
  logic                   unused_target_lsbs;

  logic                   ifid_load;
  logic                   ifid_bubble;
  logic [INSTR_WIDTH-1:0] ifid_instr;
  logic [ADDR_WIDTH-1:0]  ifid_pc;
  logic [ADDR_WIDTH-1:0]  ifid_pc_plus4;

  // Instructions are word aligned, so the low target bits carry no information.
  assign target_aligned     = {i_target_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_target_lsbs = ^i_target_pc[1:0];
  assign fetch_pc_plus4     = fetch_pc_q + ADDR_WIDTH'(4);
  assign skid_pc_plus4      = skid_pc_q + ADDR_WIDTH'(4);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= S_BOOT;
      fetch_pc_q     <= RESET_PC;
      skid_instr_q   <= NOP_INSTR;
      skid_pc_q      <= '0;
      drain_target_q <= '0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      skid_instr_q   <= skid_instr_d;
      skid_pc_q      <= skid_pc_d;
      drain_target_q <= drain_target_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    skid_instr_d   = skid_instr_q;
    skid_pc_d      = skid_pc_q;
    drain_target_d = drain_target_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
        if (i_flush) fetch_pc_d = target_aligned;
      end
      S_REQ: begin
        if (i_flush) begin
          // An unacked request cannot be abandoned; park the target until it completes.
          if (i_imem_ack) begin
            fetch_pc_d = target_aligned;
          end else begin
            drain_target_d = target_aligned;
            state_d        = S_DRAIN;
          end
        end else if (i_imem_ack) begin
          if (i_stall) begin
            skid_instr_d = i_imem_rdata;
            skid_pc_d    = fetch_pc_q;
            state_d      = S_HOLD;
          end else begin
            fetch_pc_d = fetch_pc_plus4;
          end
        end
      end
      S_HOLD: begin
        if (i_flush) begin
          fetch_pc_d = target_aligned;
          state_d    = S_REQ;
        end else if (!i_stall) begin
          fetch_pc_d = fetch_pc_plus4;
          state_d    = S_REQ;
        end
      end
      S_DRAIN: begin
        if (i_imem_ack) begin
          fetch_pc_d = i_flush ? target_aligned : drain_target_q;
          state_d    = S_REQ;
        end else if (i_flush) begin
          drain_target_d = target_aligned;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    o_imem_req    = (state_q == S_REQ) || (state_q == S_DRAIN);
    o_imem_addr   = fetch_pc_q;
    ifid_load     = 1'b0;
    ifid_bubble   = 1'b0;
    ifid_instr    = i_imem_rdata;
    ifid_pc       = fetch_pc_q;
    ifid_pc_plus4 = fetch_pc_plus4;
    if (i_flush) begin
      ifid_bubble = 1'b1;
    end else begin
      case (state_q)
        S_REQ: begin
          if (!i_stall) begin
            ifid_load   = i_imem_ack;
            ifid_bubble = !i_imem_ack;
          end
        end
        S_HOLD: begin
          if (!i_stall) begin
            ifid_load     = 1'b1;
            ifid_instr    = skid_instr_q;
            ifid_pc       = skid_pc_q;
            ifid_pc_plus4 = skid_pc_plus4;
          end
        end
        S_DRAIN: ifid_bubble = 1'b1;
        default: ;
      endcase
    end
  end

  if_id_reg #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_if_id (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (ifid_load),
    .i_bubble   (ifid_bubble),
    .i_instr    (ifid_instr),
    .i_pc       (ifid_pc),
    .i_pc_plus4 (ifid_pc_plus4),
    .o_instr    (o_instr),
    .o_pc       (o_pc),
    .o_pc_plus4 (o_pc_plus4),
    .o_valid    (o_bubble)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a directed cycle table, a randomized run against an
// instruction-stream model, and a wrap-around / mid-drain reset sequence.
module tb_fetch_stage;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        ack;
    logic [31:0] target;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_bub;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_p4;
  } vec_t;

  localparam int NV = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, stall_a, flush_a, ack_a, req_a, bub_a;
  logic [31:0] target_a, rdata_a, addr_a, instr_a, pc_a, p4_a;
  logic        rst_b, stall_b, flush_b, ack_b, req_b, bub_b;
  logic [31:0] target_b, rdata_b, addr_b, instr_b, pc_b, p4_b;

  int checks   = 0;
  int failures = 0;

  vec_t        vecs[NV];
  vec_t        v;
  logic        prev_stall, prev_flush, prev_req, prev_ack;
  logic [31:0] prev_target, prev_addr;
  logic [31:0] snap_instr, snap_pc, snap_p4;
  logic        snap_bub;
  logic [31:0] exp_pc;
  int          deliveries;

  fetch_stage #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_stall(stall_a), .i_flush(flush_a),
    .i_target_pc(target_a), .o_imem_req(req_a), .o_imem_addr(addr_a),
    .i_imem_ack(ack_a), .i_imem_rdata(rdata_a), .o_instr(instr_a),
    .o_pc(pc_a), .o_pc_plus4(p4_a), .o_bubble(bub_a)
  );

  fetch_stage #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_stall(stall_b), .i_flush(flush_b),
    .i_target_pc(target_b), .o_imem_req(req_b), .o_imem_addr(addr_b),
    .i_imem_ack(ack_b), .i_imem_rdata(rdata_b), .o_instr(instr_b),
    .o_pc(pc_b), .o_pc_plus4(p4_b), .o_bubble(bub_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic f, input logic a,
                              input logic [31:0] t, input logic [31:0] rd,
                              input logic er, input logic [31:0] ea, input logic eb,
                              input logic [31:0] ei, input logic [31:0] ep,
                              input logic [31:0] e4);
    vec_t r;
    r.stall = s; r.flush = f; r.ack = a; r.target = t; r.rdata = rd;
    r.e_req = er; r.e_addr = ea; r.e_bub = eb; r.e_instr = ei; r.e_pc = ep; r.e_p4 = e4;
    return r;
  endfunction

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  initial begin
    // Row: inputs this cycle (stall, flush, ack, target, rdata), then outputs expected
    // at the start of the cycle (req, addr, bubble, instr, pc, pc+4).
    vecs[0]  = mk(0, 0, 0, 32'h0,  32'h0,         0, 32'h0,  0, 32'h0,         32'h0,  32'h0);
    vecs[1]  = mk(0, 0, 1, 32'h0,  32'h2008_0005, 1, 32'h0,  0, 32'h0,         32'h0,  32'h0);
    vecs[2]  = mk(0, 0, 1, 32'h0,  32'h0,         1, 32'h4,  1, 32'h2008_0005, 32'h0,  32'h4);
    vecs[3]  = mk(1, 0, 1, 32'h0,  32'h8D09_0004, 1, 32'h8,  1, 32'h0,         32'h4,  32'h8);
    vecs[4]  = mk(1, 0, 0, 32'h0,  32'h0,         0, 32'h8,  1, 32'h0,         32'h4,  32'h8);
    vecs[5]  = mk(1, 0, 0, 32'h0,  32'h0,         0, 32'h8,  1, 32'h0,         32'h4,  32'h8);
    vecs[6]  = mk(0, 0, 0, 32'h0,  32'h0,         0, 32'h8,  1, 32'h0,         32'h4,  32'h8);
    vecs[7]  = mk(0, 1, 1, 32'h43, 32'h1111_1111, 1, 32'hC,  1, 32'h8D09_0004, 32'h8,  32'hC);
    vecs[8]  = mk(0, 0, 0, 32'h0,  32'h0,         1, 32'h40, 0, 32'h0,         32'h8,  32'hC);
    vecs[9]  = mk(0, 0, 1, 32'h0,  32'h2222_2222, 1, 32'h40, 0, 32'h0,         32'h8,  32'hC);
    vecs[10] = mk(0, 1, 0, 32'h80, 32'h0,         1, 32'h44, 1, 32'h2222_2222, 32'h40, 32'h44);
    vecs[11] = mk(0, 0, 0, 32'h0,  32'h0,         1, 32'h44, 0, 32'h0,         32'h40, 32'h44);
    vecs[12] = mk(0, 0, 0, 32'h0,  32'h0,         1, 32'h44, 0, 32'h0,         32'h40, 32'h44);
    vecs[13] = mk(0, 0, 1, 32'h0,  32'h3333_3333, 1, 32'h44, 0, 32'h0,         32'h40, 32'h44);
    vecs[14] = mk(0, 0, 1, 32'h0,  32'h4444_4444, 1, 32'h80, 0, 32'h0,         32'h40, 32'h44);
    vecs[15] = mk(1, 0, 1, 32'h0,  32'h5555_5555, 1, 32'h84, 1, 32'h4444_4444, 32'h80, 32'h84);
    vecs[16] = mk(1, 1, 0, 32'hC0, 32'h0,         0, 32'h84, 1, 32'h4444_4444, 32'h80, 32'h84);
    vecs[17] = mk(0, 0, 1, 32'h0,  32'h6666_6666, 1, 32'hC0, 0, 32'h0,         32'h80, 32'h84);
    vecs[18] = mk(0, 0, 0, 32'h0,  32'h0,         1, 32'hC4, 1, 32'h6666_6666, 32'hC0, 32'hC4);
    vecs[19] = mk(0, 0, 0, 32'h0,  32'h0,         1, 32'hC4, 0, 32'h0,         32'hC0, 32'hC4);

    rst_a = 1'b1; stall_a = 0; flush_a = 0; ack_a = 0; target_a = '0; rdata_a = '0;
    rst_b = 1'b1; stall_b = 0; flush_b = 0; ack_b = 0; target_b = '0; rdata_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", req_a, 0);
    chk("rst_bubble", bub_a, 0);
    chk("rst_instr", instr_a, 0);
    chk("rst_pc", pc_a, 0);
    chk("rst_pc_plus4", p4_a, 0);
    rst_a = 1'b0;

    // Directed cycle table
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      chk($sformatf("vec%0d_req", i), req_a, v.e_req);
      if (v.e_req) chk($sformatf("vec%0d_addr", i), addr_a, v.e_addr);
      chk($sformatf("vec%0d_bubble", i), bub_a, v.e_bub);
      chk($sformatf("vec%0d_instr", i), instr_a, v.e_instr);
      chk($sformatf("vec%0d_pc", i), pc_a, v.e_pc);
      chk($sformatf("vec%0d_pc_plus4", i), p4_a, v.e_p4);
      stall_a = v.stall; flush_a = v.flush; ack_a = v.ack;
      target_a = v.target; rdata_a = v.rdata;
      @(negedge clk);
    end

    // Randomized run: the model tracks only the PC of the next instruction decode must see.
    stall_a = 0; flush_a = 0; ack_a = 0;
    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    exp_pc = 32'h0; deliveries = 0;
    prev_stall = 0; prev_flush = 0; prev_req = 0; prev_ack = 0;
    prev_target = '0; prev_addr = '0;
    snap_instr = instr_a; snap_pc = pc_a; snap_p4 = p4_a; snap_bub = bub_a;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_req && !prev_ack) begin
        chk("rnd_req_held", req_a, 1);
        chk("rnd_addr_held", addr_a, prev_addr);
      end
      if (prev_flush) begin
        chk("rnd_flush_bubble", bub_a, 0);
        chk("rnd_flush_instr", instr_a, 0);
        exp_pc = prev_target & 32'hFFFF_FFFC;
      end else if (prev_stall) begin
        chk("rnd_stall_bubble", bub_a, snap_bub);
        chk("rnd_stall_instr", instr_a, snap_instr);
        chk("rnd_stall_pc", pc_a, snap_pc);
        chk("rnd_stall_pc_plus4", p4_a, snap_p4);
      end else if (bub_a) begin
        chk("rnd_pc", pc_a, exp_pc);
        chk("rnd_instr", instr_a, mem_word(exp_pc));
        chk("rnd_pc_plus4", p4_a, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end else begin
        chk("rnd_bubble_instr", instr_a, 0);
      end
      snap_instr = instr_a; snap_pc = pc_a; snap_p4 = p4_a; snap_bub = bub_a;
      prev_req = req_a; prev_addr = addr_a;

      stall_a  = ($urandom_range(0, 3) == 0);
      flush_a  = ($urandom_range(0, 11) == 0);
      target_a = $urandom & 32'h0000_0FFF;
      ack_a    = req_a && ($urandom_range(0, 4) < 3);
      rdata_a  = ack_a ? mem_word(addr_a) : $urandom;
      prev_stall = stall_a; prev_flush = flush_a;
      prev_target = target_a; prev_ack = ack_a;
      @(negedge clk);
    end
    chk("rnd_enough_deliveries", (deliveries > 200) ? 32'd1 : 32'd0, 32'd1);
    stall_a = 0; flush_a = 0; ack_a = 0;

    // Wrap-around from RESET_PC=FFFF_FFFC, then asynchronous reset in the middle of a drain
    @(negedge clk);
    rst_b = 1'b0;
    chk("b_boot_req", req_b, 0);
    @(negedge clk);
    chk("b_first_req", req_b, 1);
    chk("b_first_addr", addr_b, 32'hFFFF_FFFC);
    ack_b = 1; rdata_b = 32'hABCD_0001;
    @(negedge clk);
    chk("b_wrap_addr", addr_b, 32'h0);
    chk("b_wrap_pc", pc_b, 32'hFFFF_FFFC);
    chk("b_wrap_pc_plus4", p4_b, 32'h0);
    chk("b_wrap_bubble", bub_b, 1);
    chk("b_wrap_instr", instr_b, 32'hABCD_0001);
    ack_b = 0; flush_b = 1; target_b = 32'h100;
    @(negedge clk);
    flush_b = 0;
    chk("b_drain_req", req_b, 1);
    chk("b_drain_addr", addr_b, 32'h0);
    chk("b_drain_bubble", bub_b, 0);
    @(posedge clk);
    #2 rst_b = 1'b1;
    #1;
    chk("b_async_req", req_b, 0);
    chk("b_async_addr", addr_b, 32'hFFFF_FFFC);
    chk("b_async_bubble", bub_b, 0);
    chk("b_async_instr", instr_b, 0);
    chk("b_async_pc", pc_b, 0);
    chk("b_async_pc_plus4", p4_b, 0);
    @(negedge clk);
    rst_b = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register. Feeds the decode/control stage.
- Owns the PC and drives a req/ack instruction-memory port.
- Presents instruction, PC and PC+4 to decode, with o_bubble as the valid flag (1 = real instruction, 0 = bubble). o_bubble wires directly to the control unit's i_bubble.
- Handles stalls from the hazard unit and redirects (flush) from resolved branches and jumps.

Parameters:
- ADDR_WIDTH, 32, PC / imem address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_stall  in  1  hold IF/ID contents and PC (load-use hazard).
- i_flush  in  1  redirect: discard fetched/held instruction, jump to i_target_pc.
- i_target_pc  in  ADDR_WIDTH  redirect address; bits [1:0] ignored (treated as 0).
- o_imem_req  out  1  fetch request.
- o_imem_addr  out  ADDR_WIDTH  fetch address; stable while req=1 and no ack.
- i_imem_ack  in  1  data valid this cycle; may be asserted in the same cycle as req (zero-wait).
- i_imem_rdata  in  32  instruction word, valid when ack=1.
- o_instr  out  32  IF/ID instruction; 0 (NOP) when bubble.
- o_pc  out  ADDR_WIDTH  IF/ID PC of o_instr.
- o_pc_plus4  out  ADDR_WIDTH  IF/ID PC+4.
- o_bubble  out  1  1 = IF/ID holds a valid instruction; 0 = bubble.

Behaviour:
- Reset (async, immediate):
  - fetch_pc=RESET_PC, state=S_BOOT, o_imem_req=0, o_bubble=0.
  - o_instr=0, o_pc=0, o_pc_plus4=0, skid buffer cleared.
- FSM states: S_BOOT, S_REQ, S_HOLD, S_DRAIN.
- S_BOOT: req=0 for one cycle, then S_REQ.
- S_REQ: req=1, addr=fetch_pc.
  - ack & !stall: IF/ID <= {rdata, fetch_pc, fetch_pc+4}, o_bubble<=1; fetch_pc+=4; stay S_REQ. Sustains 1 instr/cycle with zero-wait memory.
  - ack & stall: rdata and fetch_pc captured into skid; IF/ID unchanged; go S_HOLD.
  - !ack & !stall: o_bubble<=0, o_instr<=0; IF/ID pc fields keep their old value.
  - !ack & stall: IF/ID unchanged.
- S_HOLD: req=0.
  - !stall: IF/ID <= skid, o_bubble<=1, fetch_pc+=4, go S_REQ.
  - stall: hold.
- S_DRAIN: req=1 with the old address until ack. Ack data is discarded, then fetch_pc <= saved target and go S_REQ.
- Flush has highest priority and overrides stall in every state. IF/ID <= bubble (o_bubble=0, o_instr=0).
  - S_REQ with ack same cycle: data discarded; fetch_pc<=target; stay S_REQ.
  - S_REQ without ack: target saved; go S_DRAIN. The memory contract forbids abandoning an outstanding request.
  - S_HOLD: skid discarded; fetch_pc<=target; go S_REQ.
  - S_DRAIN: saved target overwritten by the newest target.
  - S_BOOT: fetch_pc<=target.
- Stall never inserts a bubble. Decode sees the same instruction with o_bubble unchanged for the whole stall.
- Arithmetic: PC+4 is modulo 2^ADDR_WIDTH (32'hFFFF_FFFC -> 0). Target bits [1:0] are forced to 0.
- Latency: instruction acked in cycle N is visible on IF/ID outputs in cycle N+1.

Decomposition:
- Shared package (cpu_pkg):
  - state encodings S_BOOT/S_REQ/S_HOLD/S_DRAIN;
  - NOP_INSTR=32'h0;
  - default RESET_PC;
  - INSTR_WIDTH=32.
- Sub-module if_id_reg: the IF/ID register with load/bubble/hold controls and asynchronous reset. Reused by the later ID/EX register pattern.

Test Plan:
- Reset release, zero-wait memory returning 0x20080005 @0, 0x00000000 @4: first req at cycle 2, addr 0. o_instr=0x20080005, o_pc=0, o_pc_plus4=4, o_bubble=1 the next cycle. Sequence continues at 4, 8.
- Stall for 3 cycles while ack arrives with 0x8D090004: IF/ID unchanged and req=0 during the stall. After stall drops, o_instr=0x8D090004 with o_bubble=1 and no lost or duplicated fetch.
- Flush (target 0x40) with ack in the same cycle: o_bubble=0, o_instr=0 next cycle. Next req addr=0x40 and the stale data never reaches IF/ID.
- Flush (target 0x80) while request to 0x10 is pending with 3 wait cycles: req/addr 0x10 held until ack, data dropped, then req addr=0x80. o_bubble=0 throughout the drain.
- Flush and stall asserted together in S_HOLD: flush wins, skid discarded, next fetch at target.
- RESET_PC=32'hFFFF_FFFC: after the first fetch, next addr=0 and o_pc_plus4=0. Also assert i_rst mid-drain: outputs return to reset values immediately.
